// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong match sequencer and its surroundings.
// master drives the inputs (buttons, vsync, miss flags); slave is the sequencer.
interface pong_game_ctrl_if #(
  parameter int SCORE_W = 4
);
  logic               i_start;
  logic               i_vsync;
  logic               i_p1_miss;
  logic               i_p2_miss;
  logic               o_frame_tick;
  logic               o_game_active;
  logic               o_ball_reset;
  logic               o_serve_dir;
  logic [SCORE_W-1:0] o_p1_score;
  logic [SCORE_W-1:0] o_p2_score;
  logic               o_game_over;
  logic               o_winner;
  logic [2:0]         o_state;

  modport master (
    output i_start, i_vsync, i_p1_miss, i_p2_miss,
    input  o_frame_tick, o_game_active, o_ball_reset, o_serve_dir,
           o_p1_score, o_p2_score, o_game_over, o_winner, o_state
  );

  modport slave (
    input  i_start, i_vsync, i_p1_miss, i_p2_miss,
    output o_frame_tick, o_game_active, o_ball_reset, o_serve_dir,
           o_p1_score, o_p2_score, o_game_over, o_winner, o_state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: game state, scores, serve timing and ball reset.
// Define PONG_AUTO_SERVE_EN to serve again right after a non-final point instead of waiting for start.
module pong_game_ctrl #(
  parameter int SCORE_LIMIT  = 9,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int FRAME_CNT_W  = 7
) (
  input logic              clk,
  input logic              i_rst_n,
  pong_game_ctrl_if.slave  bus
);
  // state | meaning
  // IDLE  | no match, scores cleared, waiting for start
  // SERVE | ball held at centre for SERVE_FRAMES frame ticks
  // PLAY  | ball moving, watching miss flags
  // POINT | one cycle: credit the scorer, check for match end
  // WAIT  | between rallies, waiting for start
  // OVER  | match finished, scores frozen
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  localparam logic [SCORE_W-1:0]     LIMIT    = SCORE_W'(SCORE_LIMIT);
  localparam logic [FRAME_CNT_W-1:0] CNT_LOAD = FRAME_CNT_W'(SERVE_FRAMES - 1);

  logic [2:0]             r_state;
  logic                   r_vsync_d;
  logic                   r_start_d;
  logic                   r_frame_tick;
  logic                   r_start_evt;
  logic                   r_serve_dir;
  logic                   r_winner;
  logic                   r_scorer;
  logic [FRAME_CNT_W-1:0] r_cnt;
  logic [SCORE_W-1:0]     r_p1_score;
  logic [SCORE_W-1:0]     r_p2_score;
  logic [SCORE_W-1:0]     w_cur_score;
  logic                   w_final;

  assign w_cur_score = r_scorer ? r_p2_score : r_p1_score;
  assign w_final     = (w_cur_score == LIMIT - 1'b1);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vsync_d    <= 1'b0;
      r_start_d    <= 1'b0;
      r_frame_tick <= 1'b0;
      r_start_evt  <= 1'b0;
    end else begin
      r_vsync_d    <= bus.i_vsync;
      r_start_d    <= bus.i_start;
      r_frame_tick <= bus.i_vsync & ~r_vsync_d;
      r_start_evt  <= bus.i_start & ~r_start_d;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_serve_dir <= 1'b0;
      r_winner    <= 1'b0;
      r_scorer    <= 1'b0;
      r_cnt       <= '0;
      r_p1_score  <= '0;
      r_p2_score  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_p1_score <= '0;
          r_p2_score <= '0;
          if (r_start_evt) begin
            r_state <= S_SERVE;
            r_cnt   <= CNT_LOAD;
          end
        end
        S_SERVE: begin
          if (r_frame_tick) begin
            if (r_cnt == '0) r_state <= S_PLAY;
            else             r_cnt   <= r_cnt - 1'b1;
          end
        end
        S_PLAY: begin
          // simultaneous misses are treated as a dead ball and replayed
          if (bus.i_p1_miss && bus.i_p2_miss) begin
            r_state <= S_SERVE;
            r_cnt   <= CNT_LOAD;
          end else if (bus.i_p1_miss) begin
            r_scorer    <= 1'b1;
            r_serve_dir <= 1'b0;
            r_state     <= S_POINT;
          end else if (bus.i_p2_miss) begin
            r_scorer    <= 1'b0;
            r_serve_dir <= 1'b1;
            r_state     <= S_POINT;
          end
        end
        S_POINT: begin
          if (w_cur_score < LIMIT) begin
            if (r_scorer) r_p2_score <= r_p2_score + 1'b1;
            else          r_p1_score <= r_p1_score + 1'b1;
          end
          if (w_final) begin
            r_winner <= r_scorer;
            r_state  <= S_OVER;
          end else begin
`ifdef PONG_AUTO_SERVE_EN
            r_state <= S_SERVE;
            r_cnt   <= CNT_LOAD;
`else
            r_state <= S_WAIT;
`endif
          end
        end
        S_WAIT: begin
          if (r_start_evt) begin
            r_state <= S_SERVE;
            r_cnt   <= CNT_LOAD;
          end
        end
        S_OVER: begin
          if (r_start_evt) begin
            r_state    <= S_IDLE;
            r_p1_score <= '0;
            r_p2_score <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_frame_tick  = r_frame_tick;
  assign bus.o_game_active = (r_state == S_PLAY);
  assign bus.o_ball_reset  = (r_state != S_PLAY);
  assign bus.o_game_over   = (r_state == S_OVER);
  assign bus.o_serve_dir   = r_serve_dir;
  assign bus.o_winner      = r_winner;
  assign bus.o_p1_score    = r_p1_score;
  assign bus.o_p2_score    = r_p2_score;
  assign bus.o_state       = r_state;
endmodule
